// File: rtl/io_channel_unit_pkg.sv
// Shared widths and the FIFO payload type for the I/O channel block.
package io_channel_unit_pkg;
    localparam int IO_CH_W = 3;
    localparam int WORD_W  = 15;
    localparam int NUM_CH  = 8;

    typedef struct packed {
        logic [IO_CH_W-1:0] ch;
        logic [WORD_W-1:0]  data;
    } io_entry_t;
endpackage

// File: rtl/io_channel_unit_if.sv
// Core-side channel port plus peripheral-side output/input streams.
interface io_channel_unit_if;
    import io_channel_unit_pkg::*;

    logic                IO_write_en;
    logic [IO_CH_W-1:0]  IO_write_sel;
    logic [WORD_W-1:0]   IO_write_data;
    logic [IO_CH_W-1:0]  IO_read_sel;
    logic [WORD_W-1:0]   IO_read_data;
    logic                out_valid;
    logic                out_ready;
    logic [IO_CH_W-1:0]  out_ch;
    logic [WORD_W-1:0]   out_data;
    logic                in_valid;
    logic                in_ready;
    logic [IO_CH_W-1:0]  in_ch;
    logic [WORD_W-1:0]   in_data;
    logic                fifo_full;
    logic                overflow;

    modport slave (
        input  IO_write_en, IO_write_sel, IO_write_data, IO_read_sel,
        input  out_ready, in_valid, in_ch, in_data,
        output IO_read_data, out_valid, out_ch, out_data, in_ready,
        output fifo_full, overflow
    );

    modport master (
        output IO_write_en, IO_write_sel, IO_write_data, IO_read_sel,
        output out_ready, in_valid, in_ch, in_data,
        input  IO_read_data, out_valid, out_ch, out_data, in_ready,
        input  fifo_full, overflow
    );
endinterface

// File: rtl/io_channel_unit_fifo.sv
// Output-word FIFO; a push at full is still taken when a pop frees a slot the same cycle.
module io_fifo
    import io_channel_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst_l,
    input  logic                     push,
    input  io_entry_t                push_data,
    input  logic                     pop,
    output io_entry_t                head,
    output logic                     full,
    output logic                     dropped,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    io_entry_t       mem_q [DEPTH];
    io_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            do_pop, do_push;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_C) || do_pop);
        dropped  = push && !do_push;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
endmodule

// File: rtl/io_channel_unit.sv
// Channel register file with core/peripheral write paths and a queued output stream.
module io_channel_unit
    import io_channel_unit_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [NUM_CH-1:0] IN_MASK    = 8'b0000_0110,
    parameter logic [NUM_CH-1:0] OUT_MASK   = 8'b0011_1000
) (
    input  logic               clock,
    input  logic               rst_l,
    io_channel_unit_if.slave   io
);
    logic [WORD_W-1:0]           chan_q [NUM_CH];
    logic [WORD_W-1:0]           chan_d [NUM_CH];
    logic                        overflow_q, overflow_d;
    logic                        core_wr;
    logic                        push_req;
    io_entry_t                   push_entry;
    io_entry_t                   head;
    logic                        fifo_dropped;
    logic                        fifo_full_w;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Input channels are owned by the peripheral; the core can only read them.
    always_comb begin
        chan_d     = chan_q;
        core_wr    = io.IO_write_en && !IN_MASK[io.IO_write_sel];
        push_req   = 1'b0;
        push_entry = '0;
        if (core_wr) begin
            chan_d[io.IO_write_sel] = io.IO_write_data;
            if (OUT_MASK[io.IO_write_sel]) begin
                push_req   = 1'b1;
                push_entry = '{ch: io.IO_write_sel, data: io.IO_write_data};
            end
        end
        if (io.in_valid && IN_MASK[io.in_ch]) begin
            chan_d[io.in_ch] = io.in_data;
        end
        overflow_d = overflow_q || fifo_dropped;
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            overflow_q <= overflow_d;
            chan_q     <= chan_d;
        end
    end

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .rst_l     (rst_l),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (io.out_ready),
        .head      (head),
        .full      (fifo_full_w),
        .dropped   (fifo_dropped),
        .count     (fifo_count)
    );

    assign io.IO_read_data = chan_q[io.IO_read_sel];
    assign io.in_ready     = 1'b1;
    assign io.out_valid    = (fifo_count != '0);
    assign io.out_ch       = head.ch;
    assign io.out_data     = head.data;
    assign io.fifo_full    = fifo_full_w;
    assign io.overflow     = overflow_q;
endmodule

// File: tb/tb_io_channel_unit.sv
// Directed bench for io_channel_unit with a queue scoreboard for the output stream.
module tb_io_channel_unit;
    import io_channel_unit_pkg::*;

    localparam int         DEPTH = 4;
    localparam logic [7:0] IN_M  = 8'b0000_0110;
    localparam logic [7:0] OUT_M = 8'b0011_1000;

    logic clock = 1'b0;
    logic rst_l = 1'b0;

    io_channel_unit_if ifc ();

    io_channel_unit #(
        .FIFO_DEPTH (DEPTH),
        .IN_MASK    (IN_M),
        .OUT_MASK   (OUT_M)
    ) dut (
        .clock (clock),
        .rst_l (rst_l),
        .io    (ifc)
    );

    always #20 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    io_entry_t   sb [$];
    logic [14:0] exp_chan [8];
    logic        exp_ovf;

    task automatic chk(string tag, logic [14:0] obs, logic [14:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 8; i++) exp_chan[i] = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic check_all(string tag);
        io_entry_t h;
        for (int i = 0; i < 8; i++) begin
            ifc.IO_read_sel = 3'(i);
            #1;
            chk($sformatf("%s rd ch%0d", tag, i), ifc.IO_read_data, exp_chan[i]);
        end
        h = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, " out_valid"}, 15'(ifc.out_valid), 15'(sb.size() != 0));
        chk({tag, " fifo_full"}, 15'(ifc.fifo_full), 15'(sb.size() == DEPTH));
        chk({tag, " overflow"},  15'(ifc.overflow),  15'(exp_ovf));
        chk({tag, " out_ch"},    15'(ifc.out_ch),    15'(h.ch));
        chk({tag, " out_data"},  ifc.out_data,       h.data);
        $display("[%0t] %s: checked regs and stream status, sb depth %0d", $time, tag, sb.size());
    endtask

    // One clock: score any handshake, update the model, then let the edge happen.
    task automatic cycle();
        logic      pop;
        logic      pend;
        io_entry_t pe;
        @(negedge clock);
        pop  = ifc.out_ready && (sb.size() != 0);
        pend = 1'b0;
        pe   = '0;
        if (ifc.out_ready && ifc.out_valid) begin
            if (sb.size() == 0) begin
                chk("pop on empty", 15'(ifc.out_valid), 15'(0));
            end else begin
                chk("pop ch",   15'(ifc.out_ch), 15'(sb[0].ch));
                chk("pop data", ifc.out_data,    sb[0].data);
            end
        end
        if (ifc.IO_write_en && !IN_M[ifc.IO_write_sel]) begin
            exp_chan[ifc.IO_write_sel] = ifc.IO_write_data;
            if (OUT_M[ifc.IO_write_sel]) begin
                pend = 1'b1;
                pe   = '{ch: ifc.IO_write_sel, data: ifc.IO_write_data};
            end
        end
        if (ifc.in_valid && IN_M[ifc.in_ch]) exp_chan[ifc.in_ch] = ifc.in_data;
        if (pop) void'(sb.pop_front());
        if (pend) begin
            if (sb.size() < DEPTH) sb.push_back(pe);
            else exp_ovf = 1'b1;
        end
        @(posedge clock);
        #1;
        ifc.IO_write_en = 1'b0;
        ifc.in_valid    = 1'b0;
    endtask

    task automatic wr(logic [2:0] s, logic [14:0] d);
        ifc.IO_write_en   = 1'b1;
        ifc.IO_write_sel  = s;
        ifc.IO_write_data = d;
    endtask

    task automatic reset_pulse(string tag);
        rst_l = 1'b0;
        #2;
        clear_model();
        check_all({tag, " in reset"});
        rst_l = 1'b1;
    endtask

    initial begin
        ifc.IO_write_en   = 1'b0;
        ifc.IO_write_sel  = '0;
        ifc.IO_write_data = '0;
        ifc.IO_read_sel   = '0;
        ifc.out_ready     = 1'b0;
        ifc.in_valid      = 1'b0;
        ifc.in_ch         = '0;
        ifc.in_data       = '0;
        clear_model();
        #50 rst_l = 1'b1;
        @(posedge clock);
        #1;
        check_all("reset");

        // Reset while two entries are queued
        wr(3, 15'd11); cycle();
        wr(4, 15'd22); cycle();
        check_all("t1 queued");
        reset_pulse("t1");
        cycle();
        check_all("t1 after reset");

        // Output channel write, held until accepted
        wr(3, 15'o12345); cycle();
        check_all("t2 write");
        cycle(); cycle();
        check_all("t2 hold");
        ifc.out_ready = 1'b1;
        cycle();
        check_all("t2 drained");

        // Plain channel write and an attempted write to an input channel
        wr(0, 15'd7); cycle();
        check_all("t3 ch0");
        wr(1, 15'o55); cycle();
        check_all("t3 ch1 ignored");

        // Peripheral input alongside a core write
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1; ifc.in_ch = 3'd2; ifc.in_data = 15'o777;
        wr(4, 15'd5); cycle();
        check_all("t4 dual");
        ifc.in_valid = 1'b1; ifc.in_ch = 3'd5; ifc.in_data = 15'd123;
        cycle();
        check_all("t4 in ch5 dropped");
        ifc.out_ready = 1'b1;
        cycle();
        check_all("t4 drained");

        // Fill past capacity
        ifc.out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            wr(3, 15'(v)); cycle();
            if (v >= 4) check_all($sformatf("t5 write %0d", v));
        end
        ifc.out_ready = 1'b1;
        repeat (4) cycle();
        check_all("t5 drained");

        // Push accepted at full because a pop happens the same cycle
        reset_pulse("t6");
        cycle();
        ifc.out_ready = 1'b0;
        for (int v = 10; v < 14; v++) begin
            wr(5, 15'(v)); cycle();
        end
        check_all("t6 full");
        ifc.out_ready = 1'b1;
        wr(4, 15'd9); cycle();
        check_all("t6 push+pop at full");
        repeat (4) cycle();
        check_all("t6 drained");

        // Push+pop at a single entry: head advances to the new word
        wr(3, 15'd100); cycle();
        wr(3, 15'd101); cycle();
        check_all("t7 push+pop at one");
        cycle();
        check_all("t7 drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
